sysarr_out_drain: RTL
=====================

// Module: sysarr_out_drain
// PURPOSE
//  Read-side controller for the systolic-array output FIFO. Accepts result
//  elements streamed from the array bottom and pushes each into the OUT FIFO
//  via shift/shift_value. Once N elements are loaded, presents the FIFO's
//  full row to the writeback path over a valid/ready handshake.
//  Repeats for num_rows rows, then raises done.
// PARAMETERS
//  DW     16  element width in bits (sys_arr_pkg default)
//  N      4   elements per row = OUT FIFO depth (sys_arr_pkg default)
//  ROW_W  8   width of row count/address; max num_rows = 2**ROW_W-1
// PORTS
//  clk          in   1        rising-edge clock
//  nRST         in   1        reset, synchronous, active-low
//  start        in   1        1-cycle pulse; begins drain, sampled only in IDLE
//  num_rows     in   ROW_W    rows to drain; latched on start; 0 -> straight to DONE
//  abort        in   1        return to IDLE next cycle from any state
//  in_valid     in   1        array result element valid
//  in_data      in   DW       array result element
//  in_ready     out  1        element accepted when in_valid&in_ready
//  fifo_shift   out  1        OUT FIFO shift strobe
//  fifo_value   out  DW       OUT FIFO shift_value
//  fifo_out     in   DW*N     OUT FIFO contents (registered in FIFO)
//  wb_valid     out  1        row available to writeback
//  wb_ready     in   1        writeback accepts row
//  wb_data      out  DW*N     = fifo_out while wb_valid
//  wb_row       out  ROW_W    index of row presented (0-based)
//  busy         out  1        state != IDLE
//  done         out  1        1-cycle pulse after last row handshakes
// BEHAVIOUR
//  - Reset (nRST low at clk edge): state IDLE, counters 0, all outputs 0.
//  - States: IDLE -> FILL (start, num_rows!=0) | DONE (start, num_rows==0);
//    FILL -> PUSH when elem_cnt==N-1 and element accepted;
//    PUSH -> FILL on wb handshake if row_cnt<num_rows-1, else -> DONE;
//    DONE -> IDLE unconditionally (done=1 for that one cycle).
//  - FILL: in_ready=1; fifo_shift=in_valid; fifo_value=in_data (combinational,
//    zero added latency); elem_cnt increments per accepted element, wraps to 0
//    on the Nth.
//  - FIFO order: first accepted element ends in wb_data[DW-1:0], Nth in
//    wb_data[DW*N-1 -: DW] (FIFO shifts new value in at top).
//  - PUSH: entered the cycle after the Nth shift, so fifo_out already holds the
//    full row. in_ready=0, fifo_shift=0, wb_valid=1, wb_data/wb_row stable until
//    wb_ready. Handshake increments row_cnt; wb_row = row_cnt.
//  - Minimum row period: N+1 cycles (N fills + 1 push with wb_ready high).
//  - fifo_shift never asserted outside FIFO; fifo_value=0 when fifo_shift=0.
//  - start ignored while busy; abort has priority over start and handshakes:
//    next state IDLE, counters cleared, no done pulse. Abort in PUSH
//    drops the row. FIFO contents are not cleared; next drain overwrites them
//    after N shifts.
//  - start and abort in same IDLE cycle: stay IDLE.
//  - Reset mid-operation behaves as abort, plus all outputs forced to 0.
// STRUCTURE
//  - sys_arr_pkg gains: typedef enum logic [1:0] {DR_IDLE, DR_FILL, DR_PUSH,
//    DR_DONE} drain_state_t; localparam ELEM_W = $clog2(N).
//  - Single module: state reg + elem_cnt + row_cnt + latched num_rows;
//    next-state/output logic in one always_comb. No sub-module.
//  - Top level connects fifo_shift/fifo_value/fifo_out to
//    systolic_array_OUT_FIFO_if shift/shift_value/out.
// TESTING (bench instantiates this block with sysarr_OUT_FIFO, N=4, DW=16)
//  1 reset: hold nRST=0 2 cycles mid-FILL -> all outputs 0, state IDLE, no done.
//  2 start, num_rows=1, in 0x1,0x2,0x3,0x4 back-to-back, wb_ready=1 ->
//    wb_valid cycle 5 after first accept, wb_data=0x0004_0003_0002_0001,
//    wb_row=0, done next cycle.
//  3 num_rows=3, wb_ready low 3 cycles per row -> wb_data stable while stalled,
//    in_ready=0 during PUSH, wb_row 0,1,2, single done pulse.
//  4 in_valid gapped (every other cycle) -> fifo_shift only on valid, row correct.
//  5 start with num_rows=0 -> DONE then IDLE, done 1 cycle, no shift/wb_valid.
//  6 abort after 2 elements, then new start with 4 elements 0xA..0xD ->
//    no done from first run, wb_data=0x000D_000C_000B_000A.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// rtl/sys_arr_pkg.sv - shared systolic-array types and defaults
package sys_arr_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_N  = 4;
  localparam int ELEM_W = $clog2(DEF_N);

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_FILL,
    DR_PUSH,
    DR_DONE
  } drain_state_t;

endpackage

// File: rtl/sysarr_out_drain.sv
// rtl/sysarr_out_drain.sv - loads array results into the OUT FIFO and hands full rows to writeback
module sysarr_out_drain
  import sys_arr_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int N     = DEF_N,
  parameter int ROW_W = 8
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic            start,
  input  logic [ROW_W-1:0] num_rows,
  input  logic            abort,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            fifo_shift,
  output logic [DW-1:0]   fifo_value,
  input  logic [DW*N-1:0] fifo_out,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [DW*N-1:0] wb_data,
  output logic [ROW_W-1:0] wb_row,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  drain_state_t      state_q, state_d;
  logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0]  num_rows_q, num_rows_d;
  logic              last_row;

  // The row just handed off is the last one when row_cnt+1 reaches num_rows.
  assign last_row = ({1'b0, row_cnt_q} + (ROW_W+1)'(1)) >= {1'b0, num_rows_q};

  // Next-state and outputs; outputs are zeroed whenever reset is asserted.
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    row_cnt_d  = row_cnt_q;
    num_rows_d = num_rows_q;
    in_ready   = 1'b0;
    fifo_shift = 1'b0;
    fifo_value = '0;
    wb_valid   = 1'b0;
    wb_data    = '0;
    wb_row     = '0;
    done       = 1'b0;
    busy       = (state_q != DR_IDLE);

    case (state_q)
      DR_IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          elem_cnt_d = '0;
          row_cnt_d  = '0;
          state_d    = (num_rows == '0) ? DR_DONE : DR_FILL;
        end
      end
      DR_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fifo_shift = 1'b1;
          fifo_value = in_data;
          if (elem_cnt_q == CNT_W'(N-1)) begin
            elem_cnt_d = '0;
            state_d    = DR_PUSH;
          end else begin
            elem_cnt_d = elem_cnt_q + CNT_W'(1);
          end
        end
      end
      DR_PUSH: begin
        wb_valid = 1'b1;
        wb_data  = fifo_out;
        wb_row   = row_cnt_q;
        if (wb_ready) begin
          if (last_row) begin
            state_d = DR_DONE;
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
            state_d   = DR_FILL;
          end
        end
      end
      DR_DONE: begin
        done    = 1'b1;
        state_d = DR_IDLE;
      end
      default: state_d = DR_IDLE;
    endcase

    // Abort wins over start and handshakes; a row in PUSH is simply dropped.
    if (abort) begin
      state_d    = DR_IDLE;
      elem_cnt_d = '0;
      row_cnt_d  = '0;
      num_rows_d = '0;
    end

    if (!nRST) begin
      in_ready   = 1'b0;
      fifo_shift = 1'b0;
      fifo_value = '0;
      wb_valid   = 1'b0;
      wb_data    = '0;
      wb_row     = '0;
      done       = 1'b0;
      busy       = 1'b0;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q    <= DR_IDLE;
      elem_cnt_q <= '0;
      row_cnt_q  <= '0;
      num_rows_q <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      row_cnt_q  <= row_cnt_d;
      num_rows_q <= num_rows_d;
    end
  end

endmodule
